// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - round-robin arbiter sharing one serial transmitter
//
// Purpose:
//   Picks one of Channels byte producers in round-robin order. It latches the
//   winner's byte into o_tx_d and drives o_tx_ce until the transmitter accepts
//   it. It then follows i_tx_busy through the frame and pulses o_done when the
//   frame ends.
//
// Optional feature:
//   SERIAL_TX_ARB_LOCK_EN - packet lock. A channel that is granted with
//   i_req_last=0 keeps exclusive ownership until it is granted with
//   i_req_last=1.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous reset, active-high
//   i_req        level request per channel, held until o_ack
//   i_req_data   flattened bytes, channel i at [i*Width +: Width]
//   i_req_last   end-of-packet marker per channel (lock feature only)
//   o_ack        one-cycle pulse: byte of that channel accepted
//   o_tx_ce      transmitter chip enable
//   o_tx_d       registered byte to transmitter
//   i_tx_busy    transmitter busy flag
//   o_active     high while the arbiter owns a frame (state != IDLE)
//   o_grant_idx  index of the channel last granted
//   o_done       one-cycle pulse when the owned frame completes
module serial_tx_arbiter #(
  parameter int Channels = 4,
  parameter int Width    = 8,
  parameter int IdxWidth = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [Channels-1:0]       i_req,
  input  logic [Channels*Width-1:0] i_req_data,
  input  logic [Channels-1:0]       i_req_last,
  output logic [Channels-1:0]       o_ack,
  output logic                      o_tx_ce,
  output logic [Width-1:0]          o_tx_d,
  input  logic                      i_tx_busy,
  output logic                      o_active,
  output logic [IdxWidth-1:0]       o_grant_idx,
  output logic                      o_done
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [Channels-1:0]   r_ack;
  logic                  r_tx_ce;
  logic [Width-1:0]      r_tx_d;
  logic [IdxWidth-1:0]   r_grant_idx;
  logic                  r_done;

  logic [Channels-1:0]   w_ack_nxt;
  logic                  w_tx_ce_nxt;
  logic [Width-1:0]      w_tx_d_nxt;
  logic [IdxWidth-1:0]   w_grant_nxt;
  logic                  w_done_nxt;

  logic                  w_found;
  logic [IdxWidth-1:0]   w_g;
  logic [Width-1:0]      w_sel_data;

`ifdef SERIAL_TX_ARB_LOCK_EN
  logic                  r_lock;
  logic                  w_lock_nxt;
`else
  logic                  w_unused_last;
  assign w_unused_last = ^i_req_last;
`endif

  // Round-robin search starting one past the last grant. When a packet lock
  // is held, only the locked channel is eligible.
  always_comb begin
    int                  c;
    logic [IdxWidth-1:0] w_c_idx;
    w_found = 1'b0;
    w_g     = r_grant_idx;
    c       = 0;
    w_c_idx = '0;
`ifdef SERIAL_TX_ARB_LOCK_EN
    if (r_lock) begin
      w_found = i_req[r_grant_idx];
      w_g     = r_grant_idx;
    end else
`endif
    begin
      for (int k = 1; k <= Channels; k++) begin
        c = int'(r_grant_idx) + k;
        if (c >= Channels) c = c - Channels;
        w_c_idx = IdxWidth'(c);
        if (!w_found && i_req[w_c_idx]) begin
          w_found = 1'b1;
          w_g     = w_c_idx;
        end
      end
    end
  end

  assign w_sel_data = i_req_data[int'(w_g)*Width +: Width];

  // State register plus the registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ack       <= '0;
      r_tx_ce     <= 1'b0;
      r_tx_d      <= '0;
      r_grant_idx <= IdxWidth'(Channels - 1);
      r_done      <= 1'b0;
`ifdef SERIAL_TX_ARB_LOCK_EN
      r_lock      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_ack       <= w_ack_nxt;
      r_tx_ce     <= w_tx_ce_nxt;
      r_tx_d      <= w_tx_d_nxt;
      r_grant_idx <= w_grant_nxt;
      r_done      <= w_done_nxt;
`ifdef SERIAL_TX_ARB_LOCK_EN
      r_lock      <= w_lock_nxt;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_found)     w_state_nxt = S_ISSUE;
      // An edge with busy low while ce is high is the transmitter's accept edge.
      S_ISSUE:     if (!i_tx_busy)  w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (i_tx_busy)   w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (!i_tx_busy)  w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    w_ack_nxt   = '0;
    w_tx_ce_nxt = r_tx_ce;
    w_tx_d_nxt  = r_tx_d;
    w_grant_nxt = r_grant_idx;
    w_done_nxt  = 1'b0;
`ifdef SERIAL_TX_ARB_LOCK_EN
    w_lock_nxt  = r_lock;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt    = w_g;
          w_tx_d_nxt     = w_sel_data;
          w_tx_ce_nxt    = 1'b1;
          w_ack_nxt[w_g] = 1'b1;
`ifdef SERIAL_TX_ARB_LOCK_EN
          // Set on a non-final byte and cleared on the final one.
          w_lock_nxt     = ~i_req_last[w_g];
`endif
        end
      end
      S_ISSUE: begin
        if (!i_tx_busy) w_tx_ce_nxt = 1'b0;
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) w_done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_ack       = r_ack;
  assign o_tx_ce     = r_tx_ce;
  assign o_tx_d      = r_tx_d;
  assign o_grant_idx = r_grant_idx;
  assign o_done      = r_done;
  assign o_active    = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb/tb_serial_tx_arbiter.sv - self-checking bench for serial_tx_arbiter
module tb_serial_tx_arbiter;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam logic [31:0] DATA = 32'h13121110;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   req;
  logic [CH*W-1:0] req_data;
  logic [CH-1:0]   req_last;
  logic [CH-1:0]   ack;
  logic            tx_ce;
  logic [W-1:0]    tx_d;
  logic            tx_busy;
  logic            active;
  logic [IW-1:0]   grant_idx;
  logic            done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_tx_arbiter #(.Channels(CH), .Width(W), .IdxWidth(IW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_ack       (ack),
    .o_tx_ce     (tx_ce),
    .o_tx_d      (tx_d),
    .i_tx_busy   (tx_busy),
    .o_active    (active),
    .o_grant_idx (grant_idx),
    .o_done      (done)
  );

  // Transmitter model: accepts on an edge with ce=1 and busy=0, then stays
  // busy for three cycles. force_busy emulates a frame started elsewhere.
  int         tx_cnt = 0;
  int         n_accepted = 0;
  logic [7:0] last_accepted = 8'h00;
  logic       force_busy = 1'b0;

  assign tx_busy = (tx_cnt != 0) || force_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt <= 0;
    end else if (tx_ce && !tx_busy) begin
      tx_cnt        <= 3;
      n_accepted    <= n_accepted + 1;
      last_accepted <= tx_d;
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    force_busy = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    bit         rst_first;
    logic [3:0] req;
    logic [3:0] last;
    logic [31:0] data;
    int         exp_g;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v, input int idx);
    int  cycles;
    bit  got;
    int  ack_cycles;
    int  ce_cycles;
    logic [31:0] exp_ack;
    if (v.rst_first) do_reset();
    req      = v.req;
    req_last = v.last;
    req_data = v.data;
    exp_ack  = 32'h1 << v.exp_g;
    cycles = 0;
    got    = 0;
    while (cycles < 20 && !got) begin
      step();
      cycles++;
      if (ack != 0) got = 1;
    end
    chk($sformatf("v%0d ack_latency", idx), 32'(cycles), 32'd1);
    chk($sformatf("v%0d ack", idx), 32'(ack), exp_ack);
    chk($sformatf("v%0d grant_idx", idx), 32'(grant_idx), 32'(v.exp_g));
    chk($sformatf("v%0d tx_d", idx), 32'(tx_d), 32'(v.exp_d));
    chk($sformatf("v%0d tx_ce", idx), 32'(tx_ce), 32'd1);
    chk($sformatf("v%0d active", idx), 32'(active), 32'd1);
    ack_cycles = 1;
    ce_cycles  = 1;
    cycles     = 0;
    while (cycles < 50 && !done) begin
      step();
      cycles++;
      if (ack != 0) ack_cycles++;
      if (tx_ce) ce_cycles++;
    end
    chk($sformatf("v%0d done_seen", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d ack_cycles", idx), 32'(ack_cycles), 32'd1);
    chk($sformatf("v%0d ce_cycles", idx), 32'(ce_cycles), 32'd1);
    chk($sformatf("v%0d active_at_done", idx), 32'(active), 32'd0);
    chk($sformatf("v%0d sent_byte", idx), 32'(last_accepted), 32'(v.exp_d));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   hold_bad;
    int   n0;
    rst      = 1'b1;
    req      = '0;
    req_data = DATA;
    req_last = 4'hF;

    // Single request.
    vecs.push_back('{1'b1, 4'b0001, 4'hF, 32'h000000A5, 0, 8'hA5});
    // Contention: all four held.
    vecs.push_back('{1'b1, 4'b1111, 4'hF, DATA, 0, 8'h10});
    vecs.push_back('{1'b0, 4'b1111, 4'hF, DATA, 1, 8'h11});
    vecs.push_back('{1'b0, 4'b1111, 4'hF, DATA, 2, 8'h12});
    vecs.push_back('{1'b0, 4'b1111, 4'hF, DATA, 3, 8'h13});
    vecs.push_back('{1'b0, 4'b1111, 4'hF, DATA, 0, 8'h10});
    // Rotation fairness with channels 0 and 2.
    vecs.push_back('{1'b1, 4'b0101, 4'hF, DATA, 0, 8'h10});
    vecs.push_back('{1'b0, 4'b0101, 4'hF, DATA, 2, 8'h12});
    vecs.push_back('{1'b0, 4'b0101, 4'hF, DATA, 0, 8'h10});
    vecs.push_back('{1'b0, 4'b0101, 4'hF, DATA, 2, 8'h12});
    // Channel 2 sends a three-byte packet while channel 0 is waiting.
`ifdef SERIAL_TX_ARB_LOCK_EN
    vecs.push_back('{1'b1, 4'b0100, 4'b0000, DATA, 2, 8'h12});
    vecs.push_back('{1'b0, 4'b0101, 4'b0000, DATA, 2, 8'h12});
    vecs.push_back('{1'b0, 4'b0101, 4'b0100, DATA, 2, 8'h12});
    vecs.push_back('{1'b0, 4'b0001, 4'hF,    DATA, 0, 8'h10});
`else
    vecs.push_back('{1'b1, 4'b0100, 4'b0000, DATA, 2, 8'h12});
    vecs.push_back('{1'b0, 4'b0101, 4'b0000, DATA, 0, 8'h10});
    vecs.push_back('{1'b0, 4'b0101, 4'b0100, DATA, 2, 8'h12});
    vecs.push_back('{1'b0, 4'b0101, 4'hF,    DATA, 0, 8'h10});
    vecs.push_back('{1'b0, 4'b0100, 4'b0100, DATA, 2, 8'h12});
`endif

    // Reset state.
    do_reset();
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst tx_ce", 32'(tx_ce), 32'd0);
    chk("rst tx_d", 32'(tx_d), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst active", 32'(active), 32'd0);
    chk("rst grant_idx", 32'(grant_idx), 32'd3);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Busy hold: transmitter busy for five cycles after ISSUE is entered.
    do_reset();
    req_data   = DATA;
    req_last   = 4'hF;
    force_busy = 1'b1;
    req        = 4'b0010;
    step();
    chk("hold ack", 32'(ack), 32'b0010);
    chk("hold tx_ce", 32'(tx_ce), 32'd1);
    chk("hold tx_d", 32'(tx_d), 32'h11);
    n0 = n_accepted;
    hold_bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!tx_ce || tx_d != 8'h11 || ack != 0) hold_bad++;
    end
    chk("hold stable", 32'(hold_bad), 32'd0);
    chk("hold none_accepted", 32'(n_accepted), 32'(n0));
    force_busy = 1'b0;
    req        = '0;
    step();
    chk("hold ce_dropped", 32'(tx_ce), 32'd0);
    chk("hold accepted", 32'(n_accepted), 32'(n0 + 1));
    chk("hold byte", 32'(last_accepted), 32'h11);
    cyc = 0;
    while (cyc < 50 && !done) begin step(); cyc++; end
    chk("hold done", 32'(done), 32'd1);

    // Reset in WAIT_DONE.
    do_reset();
    req = 4'b0001;
    step();
    chk("midrst ack", 32'(ack), 32'b0001);
    req = '0;
    step();
    step();
    chk("midrst active_before", 32'(active), 32'd1);
    chk("midrst busy_before", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst tx_ce", 32'(tx_ce), 32'd0);
    chk("midrst ack0", 32'(ack), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst active", 32'(active), 32'd0);
    chk("midrst grant_idx", 32'(grant_idx), 32'd3);
    step();
    rst = 1'b0;
    req = 4'b0010;
    step();
    chk("midrst next_ack", 32'(ack), 32'b0010);
    chk("midrst next_grant", 32'(grant_idx), 32'd1);
    req = '0;
    cyc = 0;
    while (cyc < 50 && !done) begin step(); cyc++; end
    chk("midrst next_done", 32'(done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
Round-robin arbiter that shares one SerialTx transmitter between several byte producers. It latches the granted requester's byte and drives the transmitter's ce/D inputs. It tracks the transmitter's busy flag through each frame and acknowledges the requester. It sits between the on-chip producers (status reporters, debug taps) and the single UART pin driver.

Parameters:
Channels, 4, number of requesters (2..16)
Width, 8, data bits per frame; equals the transmitter's Width
IdxWidth, 2, width of the channel index; must satisfy 2**IdxWidth >= Channels

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
req  input  Channels  request per channel; level, held until ack
req_data  input  Channels*Width  flattened bytes; channel i at bits [i*Width +: Width]
req_last  input  Channels  end-of-packet marker per channel (used only with the optional feature)
ack  output  Channels  one-cycle pulse: byte of that channel accepted
tx_ce  output  1  to transmitter ce
tx_d  output  Width  to transmitter D; registered byte
tx_busy  input  1  from transmitter busy
active  output  1  high while a frame is owned by the arbiter (state != IDLE)
grant_idx  output  IdxWidth  index of the channel last granted
done  output  1  one-cycle pulse when the owned frame completes (busy falls)

Behaviour:
- Reset (async, rst=1): state=IDLE. tx_ce=0, tx_d=0, ack=0, done=0, active=0. grant_idx=Channels-1, so channel 0 has first priority.
- Round-robin order: the search starts at grant_idx+1, wraps at Channels-1 to 0, and the first channel with req=1 wins. Unused index codes (>= Channels) never appear.
- IDLE: if req != 0 at an edge, the arbiter registers the following and moves to ISSUE:
  - grant_idx <= g
  - tx_d <= req_data of channel g
  - tx_ce <= 1
  - ack[g] <= 1
  If req == 0, the arbiter stays in IDLE.
- Latency: req rises before edge k; ack and tx_ce are high in the cycle after edge k.
- ISSUE: ack is cleared at the next edge (exactly one cycle). tx_ce stays high until an edge where tx_busy=0, which is the transmitter's accept edge. At that edge tx_ce <= 0 and state <= WAIT_BUSY. If tx_busy=1 on entry, for example a frame started outside the arbiter, the arbiter holds tx_ce and tx_d.
- WAIT_BUSY: move to WAIT_DONE on the first edge with tx_busy=1. Normally this is one cycle after accept.
- WAIT_DONE: on the edge with tx_busy=0, pulse done for one cycle and move to IDLE. A new grant is possible at the next edge, so there is one idle cycle between frames.
- Producers may change req_data or drop req after ack. Only the latched tx_d is transmitted.
- Simultaneous requests: exactly one ack per grant. Losers keep req high and are served in rotation; no channel waits more than Channels-1 frames.
- req changes during ISSUE, WAIT_BUSY or WAIT_DONE are ignored until IDLE.
- Reset mid-frame: the arbiter returns to IDLE immediately. The byte is lost from the arbiter's view and no done pulse is issued. The transmitter is reset by the same rst.
- The arbiter never asserts tx_ce while tx_busy=1 at an accept edge, so no byte is ever dropped by the transmitter.

Optional Feature:
Macro SERIAL_TX_ARB_LOCK_EN.
- Defined: packet lock. A lock flag is set when a channel is granted with req_last[g]=0. While the flag is set, IDLE considers only channel grant_idx; other requests wait even if the locked channel's req is low. The lock clears when a byte from the locked channel is granted with req_last=1. Reset clears the lock.
- Not defined: req_last is ignored and every byte is arbitrated independently.

Test Plan:
- Single request: after reset, req=4'b0001, data0=8'hA5 -> ack[0] one cycle after the edge, tx_ce high 1 cycle, tx_d=8'hA5, done pulses once tx_busy falls, grant_idx=0.
- Contention: req=4'b1111 held, data i=8'h10+i -> grant order 0,1,2,3,0 with tx_d 8'h10,8'h11,8'h12,8'h13; exactly one ack per frame.
- Rotation fairness: req=4'b0101 held -> grants alternate 0,2,0,2; channels 1 and 3 never acked.
- Busy hold: tx_busy forced 1 for 5 cycles when ISSUE is entered -> tx_ce stays 1 with tx_d stable, accepted on the first edge with tx_busy=0, no byte lost.
- Reset mid-frame: assert rst during WAIT_DONE -> tx_ce=0, ack=0, done=0, active=0 immediately, grant_idx=Channels-1. The next req=4'b0010 is granted to channel 1.
- Lock (SERIAL_TX_ARB_LOCK_EN): channel 2 sends 3 bytes with req_last=0,0,1 while req[0]=1 -> channel 0 is acked only after channel 2's third byte. Without the macro, grants interleave 2,0,2,0,2.
